// File: rtl/mult_pkg.sv
// Shared widths and operand/product types for the multiplier datapath.
// WIDTH is the operand width; PWIDTH is the full-precision product width.
package mult_pkg;

    localparam int WIDTH  = 32;
    localparam int PWIDTH = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0]  operand_t;
    typedef logic signed [PWIDTH-1:0] product_t;

endpackage

// File: rtl/normal_multiplier_core.sv
// Combinational signed multiplier core built from shifted partial products.
// Ports: a, b (signed W-bit operands) -> p (exact signed 2*W-bit product).
module normal_multiplier_core
    import mult_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] row;
    logic [2*W-1:0] acc;

    assign a_ext = {{W{a[W-1]}}, a};

    // Row i is the sign-extended multiplicand weighted by b[i]. The MSB
    // of b carries weight -2^(W-1), so its row is subtracted rather than
    // added. Rows are accumulated in a ripple chain.
    always_comb begin
        acc = '0;
        row = '0;
        for (int i = 0; i < W; i++) begin
            row = b[i] ? (a_ext << i) : '0;
            if (i == W - 1) begin
                acc = acc - row;
            end else begin
                acc = acc + row;
            end
        end
    end

    assign p = acc;

endmodule

// File: rtl/normal_multiplier.sv
// Two-stage pipelined signed WIDTH x WIDTH multiplier, one pair per clock.
// Ports: clk, rst (async high), in_valid/A/B in; out_valid/P (2*WIDTH) out.
module normal_multiplier #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   P
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               v1_q, v1_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               ov_q, ov_d;
    logic [2*WIDTH-1:0] core_p;

    normal_multiplier_core #(
        .W(WIDTH)
    ) u_core (
        .a(a_q),
        .b(b_q),
        .p(core_p)
    );

    // Operands and product only load on valid so X on idle inputs
    // never reaches P.
    always_comb begin
        a_d  = in_valid ? A : a_q;
        b_d  = in_valid ? B : b_q;
        v1_d = in_valid;
        p_d  = v1_q ? core_p : p_q;
        ov_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            p_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            v1_q <= v1_d;
            p_q  <= p_d;
            ov_q <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign P         = p_q;

endmodule

// File: tb/tb_normal_multiplier.sv
// Directed and randomized checks for the pipelined signed multiplier.
// Drives inputs 1 ns after each rising edge and samples there as well.
module tb_normal_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic [63:0] P;

    int passed = 0;
    int total  = 0;

    logic [63:0] exp_q[$];

    normal_multiplier dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .A(A),
        .B(B),
        .out_valid(out_valid),
        .P(P)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = v;
        A = a;
        B = b;
    endtask

    function automatic logic [63:0] golden(input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Issue one pair, let it pass both stages, and check the result.
    task automatic one(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] expv);
        drive(1'b1, a, b);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        chk({tag, "_ov"}, {63'b0, out_valid}, 64'd1);
        chk(tag, P, expv);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        chk("reset_ov", {63'b0, out_valid}, 64'd0);
        chk("reset_p", P, 64'd0);
        rst = 1'b0;
        cyc();

        one("pos_neg", 32'd10, -32'sd5, 64'hFFFF_FFFF_FFFF_FFCE);
        one("pos_pos", 32'd10, 32'd5, 64'h32);
        one("neg_neg", -32'sd10, -32'sd5, 64'h32);
        one("neg_pos", -32'sd10, 32'd5, 64'hFFFF_FFFF_FFFF_FFCE);
        one("zero", 32'd0, 32'd10, 64'h0);
        one("one", 32'd1, 32'd10, 64'hA);
        one("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        one("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        one("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);

        // Back-to-back stream
        drive(1'b1, 32'd25, -32'sd12);
        cyc();
        drive(1'b1, -32'sd8, 32'd9);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("stream1_ov", {63'b0, out_valid}, 64'd1);
        chk("stream1", P, 64'hFFFF_FFFF_FFFF_FED4);
        cyc();
        chk("stream2_ov", {63'b0, out_valid}, 64'd1);
        chk("stream2", P, 64'hFFFF_FFFF_FFFF_FFB8);
        cyc();
        chk("stream_idle_ov", {63'b0, out_valid}, 64'd0);
        chk("stream_hold", P, 64'hFFFF_FFFF_FFFF_FFB8);

        // Bubble with X on idle operands
        drive(1'b1, 32'd3, 32'd4);
        cyc();
        drive(1'b0, 'x, 'x);
        cyc();
        chk("bub1_ov", {63'b0, out_valid}, 64'd1);
        chk("bub1", P, 64'd12);
        drive(1'b1, 32'd5, 32'd6);
        cyc();
        drive(1'b0, 'x, 'x);
        chk("bub2_ov", {63'b0, out_valid}, 64'd0);
        chk("bub2_hold", P, 64'd12);
        cyc();
        chk("bub3_ov", {63'b0, out_valid}, 64'd1);
        chk("bub3", P, 64'd30);
        cyc();
        cyc();
        chk("x_idle_ov", {63'b0, out_valid}, 64'd0);
        chk("x_idle_hold", P, 64'd30);

        // Async reset with a pair in flight
        drive(1'b1, 32'd7, 32'd7);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ov", {63'b0, out_valid}, 64'd0);
        chk("async_rst_p", P, 64'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_ov", {63'b0, out_valid}, 64'd0);
        end
        chk("post_rst_p", P, 64'd0);

        // Random stream against a 64-bit golden model, in order
        for (int i = 0; i < 10000; i++) begin
            logic        v;
            logic [31:0] ra, rb;
            v  = ($urandom_range(0, 3) != 0);
            ra = $urandom();
            rb = $urandom();
            if (v) begin
                drive(1'b1, ra, rb);
                exp_q.push_back(golden(ra, rb));
            end else begin
                drive(1'b0, 'x, 'x);
            end
            cyc();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", {63'b0, out_valid}, 64'd0);
                end else begin
                    chk("rand", P, exp_q.pop_front());
                end
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (out_valid && exp_q.size() != 0) begin
                chk("rand_drain", P, exp_q.pop_front());
            end
        end
        chk("rand_left", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/normal_multiplier.md
Name: normal_multiplier

Overview:
- Pipelined 32x32 signed (two's-complement) multiplier producing a full-precision 64-bit product.
- Baseline ("normal") multiplier in the datapath; the reference against which alternative multiplier architectures are compared.
- Fully pipelined: accepts one operand pair per clock, fixed latency of 2 cycles.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B are valid this cycle.
- A  input  WIDTH  signed multiplicand.
- B  input  WIDTH  signed multiplier.
- out_valid  output  1  P holds a new product this cycle.
- P  output  2*WIDTH  signed product A*B.

Behaviour:
- Reset (rst=1, asynchronous assert; deassertion is synchronised externally):
  - All pipeline registers clear: out_valid=0, P=0, internal stage-1 valid=0, stage-1 operand registers=0.
- Stage 1 (edge k): A, B and in_valid are captured into operand registers.
  - Operand registers load only when in_valid=1; otherwise they hold.
  - Stage-1 valid always loads in_valid.
- Combinational core between stages: product = sign-extended A_reg * sign-extended B_reg, computed exactly to 2*WIDTH bits.
- Stage 2 (edge k+1): if stage-1 valid=1, P loads the core product; out_valid loads stage-1 valid.
  - When stage-1 valid=0, P holds its previous value.
- Latency and throughput:
  - Operands presented with in_valid before edge k appear on P with out_valid=1 after edge k+1 (2 cycles).
  - Back-to-back in_valid yields back-to-back out_valid; no stalls, no backpressure.
- Arithmetic:
  - Full two's-complement product; overflow is impossible.
  - -2^31 * -2^31 = +2^62 (0x4000_0000_0000_0000).
  - -2^31 * (2^31-1) = 0xC000_0000_8000_0000.
  - Zero and one operands are not special-cased.
- Reset mid-operation: in-flight operands are discarded; no out_valid pulse occurs for them after reset release.
- X-safety: with in_valid=0, X on A/B must not propagate to P.

Decomposition:
- Shared package mult_pkg:
  - constant WIDTH=32 and derived PWIDTH=64.
  - typedefs operand_t (signed [WIDTH-1:0]) and product_t (signed [PWIDTH-1:0]).
- One natural sub-module, normal_multiplier_core:
  - Purely combinational.
  - Generates WIDTH sign-extended partial products (Baugh-Wooley style; the MSB row is subtracted).
  - Sums them with a ripple/carry-save adder tree.
  - Must not use a behavioural '*' operator.
- Top level holds only the two pipeline stages and valid tracking.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid=0 and P=0 immediately; an in-flight pair issued the cycle before reset never produces out_valid.
- Sign combinations, each checking P 2 cycles later:
  - A=10, B=-5 -> P=0xFFFF_FFFF_FFFF_FFCE.
  - A=10, B=5 -> 0x32.
  - A=-10, B=-5 -> 0x32.
  - A=-10, B=5 -> 0xFFFF_FFFF_FFFF_FFCE.
- Identity/zero: A=0, B=10 -> 0; A=1, B=10 -> 0xA. Streaming A=25, B=-12 then A=-8, B=9 on consecutive cycles -> consecutive out_valid with P=-300 (0xFFFF_FFFF_FFFF_FED4) then -72 (0xFFFF_FFFF_FFFF_FFB8).
- Extremes:
  - 0x8000_0000 * 0x8000_0000 -> 0x4000_0000_0000_0000.
  - 0x7FFF_FFFF * 0x7FFF_FFFF -> 0x3FFF_FFFF_0000_0001.
  - 0x8000_0000 * 0x7FFF_FFFF -> 0xC000_0000_8000_0000.
- Bubbles: in_valid toggling 1,0,1 -> out_valid 1,0,1 delayed by 2 cycles; P holds across the bubble; X on A/B during in_valid=0 leaves P unchanged.
- Random: 10,000 random signed pairs with random in_valid -> every out_valid P equals a 64-bit golden model, in order.
